// File: rtl/mod_banderas_pipe_pkg.sv
// Shared definitions for the pipelined ALU status-flag block: flag bit
// positions, flag count and chunk-count helper.
package mod_banderas_pipe_pkg;

  localparam int NUM_FLAGS = 5;
  localparam int FLG_PF    = 0;
  localparam int FLG_ZF    = 1;
  localparam int FLG_SF    = 2;
  localparam int FLG_CF    = 3;
  localparam int FLG_OF    = 4;

  // Mode bits travel with the result through stage 1.
  typedef struct packed {
    logic [NUM_FLAGS-1:0] mask;
    logic                 par_odd;
    logic                 sticky;
  } mode_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mod_reduccion_chunk.sv
// One GROUP-wide reduction slice: XOR for partial parity, NOR for partial zero.
module mod_reduccion_chunk #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] par,
  input  logic [GROUP-1:0] dat,
  output logic             x,
  output logic             z
);

  assign x = ^par;
  assign z = ~|dat;

endmodule

// File: rtl/mod_banderas_pipe.sv
// Two-stage ALU flag pipeline: stage 1 registers chunked parity/zero partials,
// stage 2 folds them into the masked, optionally sticky flag register.
module mod_banderas_pipe
  import mod_banderas_pipe_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PAR_BITS = 8,
  parameter int GROUP    = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 V_IN,
  input  logic [WIDTH-1:0]     Dato,
  input  logic                 C_IN,
  input  logic                 O_IN,
  input  logic [NUM_FLAGS-1:0] MASK,
  input  logic                 PAR_ODD,
  input  logic                 STICKY,
  input  logic                 CLR,
  output logic [NUM_FLAGS-1:0] FLAGS,
  output logic                 V_OUT
);

  localparam int STAGES = 2;
  localparam int NCH    = ceil_div(WIDTH, GROUP);
  localparam int PADW   = NCH * GROUP;

  // Zero padding is neutral for both XOR and NOR, so the partial last chunk
  // and the parity chunks past PAR_BITS need no special handling.
  logic [PADW-1:0] par_pad, zro_pad;
  assign par_pad = PADW'(Dato[PAR_BITS-1:0]);
  assign zro_pad = PADW'(Dato);

  logic [NCH-1:0] cx, cz;

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_chunk
      mod_reduccion_chunk #(.GROUP(GROUP)) u_red (
        .par (par_pad[g*GROUP +: GROUP]),
        .dat (zro_pad[g*GROUP +: GROUP]),
        .x   (cx[g]),
        .z   (cz[g])
      );
    end
  endgenerate

  logic [STAGES:1] vld_pipe;
  logic [NCH-1:0]  s1_x, s1_z;
  logic            s1_msb, s1_c, s1_o;
  mode_t           s1_mode;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], V_IN};
    end
  end

  // Stage-1 payload only loads on a valid result; otherwise it is don't-care.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_x    <= '0;
      s1_z    <= '0;
      s1_msb  <= 1'b0;
      s1_c    <= 1'b0;
      s1_o    <= 1'b0;
      s1_mode <= '0;
    end else if (V_IN) begin
      s1_x    <= cx;
      s1_z    <= cz;
      s1_msb  <= Dato[WIDTH-1];
      s1_c    <= C_IN;
      s1_o    <= O_IN;
      s1_mode <= '{mask: MASK, par_odd: PAR_ODD, sticky: STICKY};
    end
  end

  logic [NUM_FLAGS-1:0] nf, base, flags_d;

  always_comb begin
    nf         = '0;
    nf[FLG_PF] = ~(^s1_x) ^ s1_mode.par_odd;
    nf[FLG_ZF] = &s1_z;
    nf[FLG_SF] = s1_msb;
    nf[FLG_CF] = s1_c;
    nf[FLG_OF] = s1_o;
  end

  // A coincident clear makes the old value read as zero for this update.
  always_comb begin
    base    = CLR ? '0 : FLAGS;
    flags_d = base;
    if (vld_pipe[1]) begin
      for (int i = 0; i < NUM_FLAGS; i++) begin
        if (s1_mode.mask[i])
          flags_d[i] = s1_mode.sticky ? (base[i] | nf[i]) : nf[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) FLAGS <= '0;
    else     FLAGS <= flags_d;
  end

  assign V_OUT = vld_pipe[STAGES];

endmodule

// File: tb/tb_mod_banderas_pipe.sv
// Bench for mod_banderas_pipe: directed table on an 8-bit instance, reset and
// partial-chunk corner cases, then a random sweep on two odd-sized instances.
module tb_mod_banderas_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       v_in, c_in, o_in, par_odd, sticky, clr;
  logic [4:0] mask;
  logic [7:0] d8;
  logic [12:0] d13;
  logic [9:0] d10;
  logic [4:0] f8, f13, f10;
  logic       vo8, vo13, vo10;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod_banderas_pipe #(.WIDTH(8), .PAR_BITS(8), .GROUP(4)) u8 (
    .CLK(clk), .RST(rst), .V_IN(v_in), .Dato(d8), .C_IN(c_in), .O_IN(o_in),
    .MASK(mask), .PAR_ODD(par_odd), .STICKY(sticky), .CLR(clr),
    .FLAGS(f8), .V_OUT(vo8));

  mod_banderas_pipe #(.WIDTH(13), .PAR_BITS(13), .GROUP(4)) u13 (
    .CLK(clk), .RST(rst), .V_IN(v_in), .Dato(d13), .C_IN(c_in), .O_IN(o_in),
    .MASK(mask), .PAR_ODD(par_odd), .STICKY(sticky), .CLR(clr),
    .FLAGS(f13), .V_OUT(vo13));

  mod_banderas_pipe #(.WIDTH(10), .PAR_BITS(7), .GROUP(3)) u10 (
    .CLK(clk), .RST(rst), .V_IN(v_in), .Dato(d10), .C_IN(c_in), .O_IN(o_in),
    .MASK(mask), .PAR_ODD(par_odd), .STICKY(sticky), .CLR(clr),
    .FLAGS(f10), .V_OUT(vo10));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Flags straight from their definitions: count ones, compare to zero, etc.
  function automatic logic [4:0] ref_flags(input int w, input int pb, input logic [31:0] d,
                                           input logic c, input logic o, input logic odd);
    int   ones = 0;
    logic pf, zf, sf;
    for (int i = 0; i < pb; i++) ones += int'(d[i]);
    pf = ((ones % 2) == int'(odd));
    zf = ((d & ((32'd1 << w) - 32'd1)) == 32'd0);
    sf = d[w-1];
    return {o, c, sf, zf, pf};
  endfunction

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       c, o;
    logic [4:0] m;
    logic       odd, st, cl;
    logic [4:0] ef;
    logic       ev;
  } vec_t;

  vec_t tbl[17];

  typedef struct {
    logic       v;
    logic [4:0] nf;
    logic [4:0] m;
    logic       st;
  } pend_t;

  pend_t      pend[2];
  logic [4:0] fm[2];
  logic [4:0] nf13, nf10, base;
  logic       ev;

  initial begin
    // Each row: inputs for one cycle, outputs expected right after its edge.
    tbl[0]  = '{1'b1, 8'h3F, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0};
    tbl[1]  = '{1'b1, 8'h07, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 5'b00001, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0};
    tbl[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 5'h1F, 1'b1, 1'b0, 1'b0, 5'b00011, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 5'b00001, 1'b1};
    tbl[7]  = '{1'b1, 8'h00, 1'b1, 1'b0, 5'b01000, 1'b0, 1'b1, 1'b0, 5'b00001, 1'b0};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b1, 1'b0, 5'b01001, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b1, 1'b0, 5'b01001, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b1, 1'b1, 5'b00000, 1'b0};
    tbl[11] = '{1'b1, 8'h00, 1'b1, 1'b0, 5'b01000, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b1, 1'b1, 5'b01000, 1'b1};
    tbl[13] = '{1'b1, 8'h00, 1'b1, 1'b1, 5'h1F, 1'b0, 1'b0, 1'b0, 5'b01000, 1'b0};
    tbl[14] = '{1'b1, 8'h80, 1'b0, 1'b1, 5'b10100, 1'b0, 1'b0, 1'b0, 5'b11011, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'b11111, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'b11111, 1'b0};

    rst = 1'b1; v_in = 1'b0; c_in = 1'b0; o_in = 1'b0; par_odd = 1'b0;
    sticky = 1'b0; clr = 1'b0; mask = 5'h00; d8 = '0; d13 = '0; d10 = '0;
    #12;
    chk("reset_flags", 32'(f8), 32'h0);
    chk("reset_vout", 32'(vo8), 32'h0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      v_in = tbl[i].v; d8 = tbl[i].d; c_in = tbl[i].c; o_in = tbl[i].o;
      mask = tbl[i].m; par_odd = tbl[i].odd; sticky = tbl[i].st; clr = tbl[i].cl;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_flags", i), 32'(f8), 32'(tbl[i].ef));
      chk($sformatf("tbl%0d_vout", i), 32'(vo8), 32'(tbl[i].ev));
    end

    // Reset with a result sitting in stage 1: flags drop now, no pulse later.
    @(negedge clk);
    v_in = 1'b1; d8 = 8'h3F; mask = 5'h1F; sticky = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
    v_in = 1'b0; rst = 1'b1;
    #1;
    chk("rst_inflight_flags", 32'(f8), 32'h0);
    chk("rst_inflight_vout", 32'(vo8), 32'h0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst%0d_vout", i), 32'(vo8), 32'h0);
      chk($sformatf("post_rst%0d_flags", i), 32'(f8), 32'h0);
    end

    // 13-bit instance with a partial last chunk.
    @(negedge clk);
    v_in = 1'b1; d13 = 13'h1001; mask = 5'h1F; par_odd = 1'b0; c_in = 1'b0; o_in = 1'b0;
    @(negedge clk) v_in = 1'b0;
    @(posedge clk); #1;
    chk("w13_vout", 32'(vo13), 32'h1);
    chk("w13_pf", 32'(f13[0]), 32'h1);
    chk("w13_zf", 32'(f13[1]), 32'h0);
    chk("w13_sf", 32'(f13[2]), 32'h1);

    // Random sweep against the behavioural model, starting from reset.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pend[k] = '{1'b0, 5'h0, 5'h0, 1'b0};
      fm[k]   = 5'h0;
    end
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      v_in    = ($urandom_range(0, 3) != 0);
      d13     = 13'($urandom);
      d10     = 10'($urandom);
      if ($urandom_range(0, 7) == 0) d13 = '0;
      if ($urandom_range(0, 7) == 0) d10 = '0;
      c_in    = 1'($urandom);
      o_in    = 1'($urandom);
      mask    = 5'($urandom);
      par_odd = 1'($urandom);
      sticky  = 1'($urandom);
      clr     = ($urandom_range(0, 9) == 0);
      nf13 = ref_flags(13, 13, 32'(d13), c_in, o_in, par_odd);
      nf10 = ref_flags(10, 7, 32'(d10), c_in, o_in, par_odd);
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        ev   = pend[k].v;
        base = clr ? 5'h0 : fm[k];
        if (pend[k].v)
          fm[k] = (pend[k].m & (pend[k].st ? (base | pend[k].nf) : pend[k].nf)) | (~pend[k].m & base);
        else
          fm[k] = base;
        pend[k] = '{v_in, (k == 0) ? nf13 : nf10, mask, sticky};
        if (k == 0) begin
          chk($sformatf("rnd%0d_w13_flags", n), 32'(f13), 32'(fm[0]));
          chk($sformatf("rnd%0d_w13_vout", n), 32'(vo13), 32'(ev));
        end else begin
          chk($sformatf("rnd%0d_w10_flags", n), 32'(f10), 32'(fm[1]));
          chk($sformatf("rnd%0d_w10_vout", n), 32'(vo10), 32'(ev));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_banderas_pipe.md
Name: mod_banderas_pipe

Overview:
- Parametrised, pipelined successor to the 6-bit combinational parity-flag block.
- Computes the ALU status flags PF (parity over a configurable low slice), ZF, SF, CF and OF from the ALU result bus.
- Holds the flags in an architectural flag register with per-flag write masks, a sticky (accumulate) mode and a clear.
- Sits between the ALU datapath output and the flag consumers (branch logic, display).

Parameters:
- WIDTH, 8, ALU result width in bits (≥2).
- PAR_BITS, 8, number of result LSBs covered by PF (1..WIDTH).
- GROUP, 4, chunk size for stage-1 partial parity/zero reduction (1..WIDTH).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- V_IN  in  1  result valid; samples all other inputs.
- Dato  in  WIDTH  ALU result.
- C_IN  in  1  carry from the ALU.
- O_IN  in  1  overflow from the ALU.
- MASK  in  5  per-flag write enable {OF,CF,SF,ZF,PF}, bit0 = PF.
- PAR_ODD  in  1  0: PF=1 on an even count of ones; 1: PF=1 on an odd count.
- STICKY  in  1  1: the written flag ORs into the stored value.
- CLR  in  1  synchronous clear of the flag register.
- FLAGS  out  5  {OF,CF,SF,ZF,PF}, registered.
- V_OUT  out  1  one-cycle pulse; FLAGS reflect a new update this cycle.

Behaviour:
- Reset (async, RST=1): FLAGS=5'b0, V_OUT=0, stage-1 valid=0. PF resets to 0 regardless of the parity mode. In-flight data is discarded; no V_OUT follows reset release.
- Stage 1 (edge after V_IN=1):
  - Register per-chunk XOR of Dato[PAR_BITS-1:0], split into ceil(PAR_BITS/GROUP) chunks; the last chunk is partial when it does not divide evenly.
  - Register per-chunk NOR of Dato[WIDTH-1:0], split into ceil(WIDTH/GROUP) chunks.
  - Register Dato[WIDTH-1], C_IN, O_IN, MASK, PAR_ODD and STICKY; set v1=1.
  - V_IN=0 sets v1=0 and leaves the captured data don't-care.
- Stage 2 (edge after v1=1), for each flag i:
  - Compute new values: PF = ~(XOR of chunks) ^ PAR_ODD; ZF = AND of zero-chunks; SF = registered MSB; CF, OF = registered C_IN, O_IN.
  - MASK[i]=0: FLAGS[i] holds.
  - MASK[i]=1, STICKY=0: FLAGS[i] ← new.
  - MASK[i]=1, STICKY=1: FLAGS[i] ← FLAGS[i] | new.
  - V_OUT=1 for exactly that cycle, even when MASK=0.
- Latency: FLAGS and V_OUT change 2 rising edges after the V_IN sample.
- Throughput: one result per cycle; back-to-back V_IN is fully supported.
- CLR without a stage-2 update: FLAGS ← 0 at the next edge, V_OUT=0.
- CLR coincident with a stage-2 update: the old value is treated as 0. Masked flags take the new value (sticky OR with 0); unmasked flags become 0.
- No backpressure; consumers must accept every V_OUT.
- Mode inputs are sampled with V_IN. A change in flight does not affect results already in stage 1.

Decomposition:
- Shared package holds:
  - Flag bit-index constants FLG_PF=0, FLG_ZF=1, FLG_SF=2, FLG_CF=3, FLG_OF=4.
  - Constant NUM_FLAGS=5.
  - A function for the ceiling-divide chunk count.
- One sub-module, mod_reduccion_chunk: parametrised GROUP-wide XOR and NOR reduction, instantiated per chunk via generate. It replaces the original hard-coded 6-input XOR.

Test Plan:
- WIDTH=8, PAR_ODD=0, MASK=5'h1F, Dato=8'h3F (6 ones), C_IN=0, O_IN=0 → two edges later FLAGS=5'b00001, V_OUT=1 for 1 cycle; Dato=8'h07 → PF=0.
- Dato=8'h00, then PAR_ODD=1 with Dato=8'h01 on back-to-back V_IN → consecutive V_OUT pulses: FLAGS=5'b00011 (PF=1, ZF=1), then FLAGS=5'b00001.
- STICKY=1, MASK=5'b01000: C_IN=1, then C_IN=0 → CF stays 1. CLR alone → FLAGS=0. CLR together with an update carrying C_IN=1 → FLAGS=5'b01000.
- Dato=8'h80, O_IN=1, MASK=5'b10100 → SF=1, OF=1; PF, ZF and CF hold their prior values.
- Assert RST with v1=1 in flight → FLAGS=0 immediately; no V_OUT after release.
- WIDTH=13, PAR_BITS=13, GROUP=4 (partial last chunk), Dato=13'h1001 → PF=1 (2 ones), ZF=0; sweep 1000 random values against a reference model.
